// File: rtl/ext_mem_host.sv
// Host initiator for CPU ext memory ports: one command at a time, write 1 cycle, read READ_LAT+1, run N cycles.
// Backpressure: cmd_ready only in IDLE; response held in RESP until rsp_ready; all outputs registered/state-decoded.
module ext_mem_host #(
   parameter int READ_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        cpu_enable,
   output logic [31:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] wdata_ext,
   output logic [31:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic [31:0] wdata_ext_2,
   input  logic [31:0] rdata_ext_2,
   output logic        busy
);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RUN, S_RESP} state_t;

   localparam logic [1:0] OP_WR_IMEM = 2'b00;
   localparam logic [1:0] OP_WR_DMEM = 2'b01;
   localparam logic [1:0] OP_RD_DMEM = 2'b10;
   localparam logic [1:0] OP_RUN     = 2'b11;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   run_n_q, run_n_d;
   logic [31:0]        rsp_data_q, rsp_data_d;
   logic [31:0]        addr_ext_q, addr_ext_d;
   logic [31:0]        wdata_ext_q, wdata_ext_d;
   logic [31:0]        addr_ext_2_q, addr_ext_2_d;
   logic [31:0]        wdata_ext_2_q, wdata_ext_2_d;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q       <= S_IDLE;
         op_q          <= 2'b00;
         cnt_q         <= '0;
         run_n_q       <= '0;
         rsp_data_q    <= '0;
         addr_ext_q    <= '0;
         wdata_ext_q   <= '0;
         addr_ext_2_q  <= '0;
         wdata_ext_2_q <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         cnt_q         <= cnt_d;
         run_n_q       <= run_n_d;
         rsp_data_q    <= rsp_data_d;
         addr_ext_q    <= addr_ext_d;
         wdata_ext_q   <= wdata_ext_d;
         addr_ext_2_q  <= addr_ext_2_d;
         wdata_ext_2_q <= wdata_ext_2_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      cnt_d         = cnt_q;
      run_n_d       = run_n_q;
      rsp_data_d    = rsp_data_q;
      addr_ext_d    = addr_ext_q;
      wdata_ext_d   = wdata_ext_q;
      addr_ext_2_d  = addr_ext_2_q;
      wdata_ext_2_d = wdata_ext_2_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d = cmd_op;
               case (cmd_op)
                  OP_WR_IMEM: begin
                     addr_ext_d  = cmd_addr;
                     wdata_ext_d = cmd_wdata;
                     state_d     = S_WRITE;
                  end
                  OP_WR_DMEM: begin
                     addr_ext_2_d  = cmd_addr;
                     wdata_ext_2_d = cmd_wdata;
                     state_d       = S_WRITE;
                  end
                  OP_RD_DMEM: begin
                     addr_ext_2_d = cmd_addr;
                     cnt_d        = CNT_W'(READ_LAT);
                     state_d      = S_READ;
                  end
                  default: begin
                     run_n_d = cmd_wdata[CNT_W-1:0];
                     cnt_d   = cmd_wdata[CNT_W-1:0];
                     if (cmd_wdata[CNT_W-1:0] == '0) begin
                        rsp_data_d = '0;
                        state_d    = S_RESP;
                     end else begin
                        state_d = S_RUN;
                     end
                  end
               endcase
            end
         end
         S_WRITE: state_d = S_IDLE;
         S_READ: begin
            // cnt_q counts remaining wait cycles; capture on the last one
            if (cnt_q == '0) begin
               rsp_data_d = rdata_ext_2;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               rsp_data_d = 32'(run_n_q);
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready   = (state_q == S_IDLE);
      busy        = (state_q != S_IDLE);
      rsp_valid   = (state_q == S_RESP);
      rsp_data    = rsp_data_q;
      cpu_enable  = (state_q == S_RUN);
      wen_ext     = (state_q == S_WRITE) && (op_q == OP_WR_IMEM);
      wen_ext_2   = (state_q == S_WRITE) && (op_q == OP_WR_DMEM);
      ren_ext     = 1'b0;
      ren_ext_2   = (state_q == S_READ);
      addr_ext    = addr_ext_q;
      wdata_ext   = wdata_ext_q;
      addr_ext_2  = addr_ext_2_q;
      wdata_ext_2 = wdata_ext_2_q;
   end

endmodule
